// File: rtl/hv_pwm_chn_sched.sv
// hv_pwm_chn_sched
// Round-robin scheduler that hands PWM bursts from several requesters to a
// single burst encoder, one burst at a time, with a guard gap between bursts
// and a watchdog on the encoder's completion pulse.
//
// Ports:
//   i_clk        clock
//   i_rst_n      synchronous active-low reset
//   i_req        per-source request level (REQ_NUM bits)
//   i_req_code   per-source code, source k at [k*CODE_W +: CODE_W]
//   o_ack        one-cycle pulse on bit k when source k's burst completed
//   o_enc_start  one-cycle start strobe to the encoder
//   o_enc_code   code of the burst currently being encoded
//   i_enc_done   one-cycle completion pulse from the encoder
//   o_busy       high in every state except IDLE
//   o_to_err     sticky encoder-timeout flag
//   i_err_clr    clears o_to_err (a simultaneous timeout wins)
module hv_pwm_chn_sched #(
  parameter int REQ_NUM = 3,
  parameter int CODE_W  = 2,
  parameter int GAP_CYC = 8,
  parameter int TO_CYC  = 64
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [REQ_NUM-1:0]        i_req,
  input  logic [REQ_NUM*CODE_W-1:0] i_req_code,
  output logic [REQ_NUM-1:0]        o_ack,
  output logic                      o_enc_start,
  output logic [CODE_W-1:0]         o_enc_code,
  input  logic                      i_enc_done,
  output logic                      o_busy,
  output logic                      o_to_err,
  input  logic                      i_err_clr
);

  localparam int IDX_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
  localparam int TO_W  = $clog2(TO_CYC) + 1;
  localparam int GAP_W = $clog2(GAP_CYC + 1) + 1;

  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_CYC - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(REQ_NUM - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   grant_idx;
  logic [TO_W-1:0]    to_cnt;
  logic [GAP_W-1:0]   gap_cnt;

  logic [CODE_W-1:0]  codes [REQ_NUM];
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   next_ptr;

  for (genvar g = 0; g < REQ_NUM; g++) begin : g_codes
    assign codes[g] = i_req_code[g*CODE_W +: CODE_W];
  end

  // Round-robin search: start at rr_ptr, walk upward with wrap, first hit wins.
  always_comb begin
    int               k;
    logic [IDX_W-1:0] kk;
    win_found = 1'b0;
    win_idx   = '0;
    k         = 0;
    kk        = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      k  = (int'(rr_ptr) + i) % REQ_NUM;
      kk = IDX_W'(k);
      if (!win_found && i_req[kk]) begin
        win_found = 1'b1;
        win_idx   = kk;
      end
    end
  end

  always_comb begin
    next_ptr = (grant_idx == IDX_LAST) ? '0 : grant_idx + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant_idx   <= '0;
      to_cnt      <= '0;
      gap_cnt     <= '0;
      o_ack       <= '0;
      o_enc_start <= 1'b0;
      o_enc_code  <= '0;
      o_busy      <= 1'b0;
      o_to_err    <= 1'b0;
    end else begin
      o_ack       <= '0;
      o_enc_start <= 1'b0;
      // A timeout set later in this block overrides the clear.
      if (i_err_clr) o_to_err <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            state       <= START;
            grant_idx   <= win_idx;
            o_enc_code  <= codes[win_idx];
            o_enc_start <= 1'b1;
            o_busy      <= 1'b1;
          end
        end
        START: begin
          state  <= WAIT;
          to_cnt <= '0;
        end
        WAIT: begin
          // Done takes priority over a timeout landing in the same cycle.
          if (i_enc_done || (to_cnt == TO_LAST)) begin
            if (i_enc_done) o_ack[grant_idx] <= 1'b1;
            else            o_to_err         <= 1'b1;
            rr_ptr <= next_ptr;
            if (GAP_CYC == 0) begin
              state  <= IDLE;
              o_busy <= 1'b0;
            end else begin
              state   <= GAP;
              gap_cnt <= '0;
            end
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state   <= IDLE;
            gap_cnt <= '0;
            o_busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hv_pwm_chn_sched.sv
// Testbench for hv_pwm_chn_sched: directed scenarios plus randomized bursts,
// checked against a transaction-level model (round-robin pick, pointer,
// sticky error flag) kept in the bench.
module tb_hv_pwm_chn_sched;

  localparam int RN  = 3;
  localparam int CW  = 2;
  localparam int GAP = 8;
  localparam int TO  = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [RN-1:0] i_req;
  logic [RN*CW-1:0] i_req_code;
  logic [RN-1:0] o_ack;
  logic          o_enc_start;
  logic [CW-1:0] o_enc_code;
  logic          i_enc_done;
  logic          o_busy;
  logic          o_to_err;
  logic          i_err_clr;

  int   checks = 0;
  int   errors = 0;
  int   m_ptr  = 0;
  logic m_err  = 1'b0;

  hv_pwm_chn_sched #(.REQ_NUM(RN), .CODE_W(CW), .GAP_CYC(GAP), .TO_CYC(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(i_req), .i_req_code(i_req_code),
    .o_ack(o_ack), .o_enc_start(o_enc_start), .o_enc_code(o_enc_code),
    .i_enc_done(i_enc_done), .o_busy(o_busy), .o_to_err(o_to_err),
    .i_err_clr(i_err_clr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_pick(input logic [RN-1:0] req, input int ptr);
    int k;
    for (int i = 0; i < RN; i++) begin
      k = (ptr + i) % RN;
      if (req[k]) return k;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; i_req = '0; i_req_code = '0; i_enc_done = 1'b0; i_err_clr = 1'b0;
    step(); step();
    rst_n = 1'b1;
    m_ptr = 0; m_err = 1'b0;
  endtask

  // One complete burst starting from IDLE. dly = WAIT cycle (1..TO) carrying
  // done, 0 = never. Returns in IDLE after the guard gap.
  task automatic run_burst(input logic [RN-1:0] req, input logic [RN*CW-1:0] codes,
                           input int dly, input bit drop, input bit clr_at_to,
                           output int g);
    int            exp_g;
    logic [CW-1:0] exp_code;
    logic [RN-1:0] exp_ack;
    exp_g    = rr_pick(req, m_ptr);
    exp_code = codes[exp_g*CW +: CW];
    i_req = req; i_req_code = codes; i_enc_done = 1'($urandom_range(0, 1));
    step();
    checks++; if (o_enc_start !== 1'b1) begin errors++; $display("FAIL start_strobe got %b want 1", o_enc_start); end
    checks++; if (o_enc_code !== exp_code) begin errors++; $display("FAIL grant_code got %b want %b", o_enc_code, exp_code); end
    checks++; if ({o_ack, o_busy} !== 4'b0001) begin errors++; $display("FAIL start_ack_busy got %b want 0001", {o_ack, o_busy}); end
    i_enc_done = 1'($urandom_range(0, 1));
    if (drop) begin i_req = '0; i_req_code = ~codes; end
    step();
    i_enc_done = 1'b0;
    for (int w = 1; w <= TO; w++) begin
      checks++; if ({o_ack, o_enc_start, o_busy} !== 5'b00001 || o_enc_code !== exp_code || o_to_err !== m_err) begin
        errors++; $display("FAIL wait_state w=%0d ack=%b start=%b busy=%b code=%b err=%b want code=%b err=%b",
                           w, o_ack, o_enc_start, o_busy, o_enc_code, o_to_err, exp_code, m_err);
      end
      i_enc_done = (dly == w);
      i_err_clr  = clr_at_to && (w == TO);
      step();
      i_enc_done = 1'b0; i_err_clr = 1'b0;
      if (dly == w) break;
    end
    if (dly != 0) exp_ack = RN'(1 << exp_g);
    else begin exp_ack = '0; m_err = 1'b1; end
    m_ptr = (exp_g + 1) % RN;
    checks++; if (o_ack !== exp_ack) begin errors++; $display("FAIL ack_pulse got %b want %b", o_ack, exp_ack); end
    checks++; if (o_to_err !== m_err) begin errors++; $display("FAIL to_err got %b want %b", o_to_err, m_err); end
    for (int c = 0; c < GAP; c++) begin
      checks++; if ({o_enc_start, o_busy} !== 2'b01 || (c > 0 && o_ack !== '0)) begin
        errors++; $display("FAIL gap_cycle c=%0d start=%b busy=%b ack=%b want start=0 busy=1", c, o_enc_start, o_busy, o_ack);
      end
      i_enc_done = 1'($urandom_range(0, 1));
      step();
    end
    i_enc_done = 1'b0;
    checks++; if ({o_ack, o_enc_start, o_busy, o_to_err} !== {5'b00000, m_err}) begin
      errors++; $display("FAIL back_to_idle ack=%b start=%b busy=%b err=%b want 0,0,0,%b", o_ack, o_enc_start, o_busy, o_to_err, m_err);
    end
    g = exp_g;
  endtask

  task automatic clear_err();
    i_req = '0; i_err_clr = 1'b1;
    step();
    i_err_clr = 1'b0; m_err = 1'b0;
    checks++; if (o_to_err !== 1'b0) begin errors++; $display("FAIL err_clear got %b want 0", o_to_err); end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if ({o_ack, o_enc_start, o_enc_code, o_busy, o_to_err} !== 8'h00) begin
      errors++; $display("FAIL reset_outputs got %b want 00000000", {o_ack, o_enc_start, o_enc_code, o_busy, o_to_err});
    end
  endtask

  task automatic test_idle();
    i_req = '0;
    for (int i = 0; i < 6; i++) begin
      i_enc_done = 1'($urandom_range(0, 1)); i_req_code = RN*CW'($urandom);
      step();
      checks++; if ({o_ack, o_enc_start, o_busy} !== 5'b0) begin
        errors++; $display("FAIL idle_hold ack=%b start=%b busy=%b want 0", o_ack, o_enc_start, o_busy);
      end
    end
    i_enc_done = 1'b0;
  endtask

  task automatic test_single();
    int g;
    run_burst(3'b010, 6'b00_11_00, 5, 1'b0, 1'b0, g);
    checks++; if (g !== 1) begin errors++; $display("FAIL single_grant got %0d want 1", g); end
  endtask

  task automatic test_fairness();
    int g;
    int order [4] = '{0, 1, 2, 0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      run_burst(3'b111, 6'b10_01_11, 1, 1'b0, 1'b0, g);
      checks++; if (g !== order[i]) begin errors++; $display("FAIL fair_order i=%0d got %0d want %0d", i, g, order[i]); end
    end
  endtask

  task automatic test_timeout();
    int g;
    run_burst(3'b001, 6'b00_00_10, 0, 1'b0, 1'b0, g);
    run_burst(3'b011, 6'b00_01_10, 3, 1'b0, 1'b0, g);
    checks++; if (g !== 1) begin errors++; $display("FAIL post_timeout_grant got %0d want 1", g); end
    clear_err();
  endtask

  task automatic test_collision();
    int g;
    run_burst(3'b100, 6'b01_00_00, TO, 1'b0, 1'b0, g);
    run_burst(3'b010, 6'b00_10_00, 0, 1'b0, 1'b1, g);
    clear_err();
  endtask

  task automatic test_drop();
    int g;
    run_burst(3'b001, 6'b00_00_01, 7, 1'b1, 1'b0, g);
    run_burst(3'b110, 6'b11_10_00, 2, 1'b1, 1'b0, g);
  endtask

  task automatic test_reset_mid();
    int g;
    i_req = 3'b100; i_req_code = 6'b11_00_00;
    step(); step(); step();
    rst_n = 1'b0; i_enc_done = 1'b1;
    step();
    i_enc_done = 1'b0; i_req = '0;
    checks++; if ({o_ack, o_enc_start, o_enc_code, o_busy, o_to_err} !== 8'h00) begin
      errors++; $display("FAIL mid_reset_outputs got %b want 00000000", {o_ack, o_enc_start, o_enc_code, o_busy, o_to_err});
    end
    step();
    rst_n = 1'b1; m_ptr = 0; m_err = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if ({o_ack, o_busy} !== 4'b0) begin errors++; $display("FAIL mid_reset_quiet ack=%b busy=%b want 0", o_ack, o_busy); end
    end
    run_burst(3'b111, 6'b01_10_11, 4, 1'b0, 1'b0, g);
  endtask

  task automatic test_random();
    int g, r, dly;
    bit drop, clr;
    for (int n = 0; n < 25; n++) begin
      r = $urandom_range(0, 9);
      dly = (r == 0) ? 0 : (r == 1) ? TO : $urandom_range(1, 12);
      drop = 1'($urandom_range(0, 1));
      clr = (dly == 0) && ($urandom_range(0, 1) == 1);
      run_burst(RN'($urandom_range(1, 7)), RN*CW'($urandom), dly, drop, clr, g);
      if (m_err && $urandom_range(0, 1) == 1) clear_err();
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single();
    test_fairness();
    test_timeout();
    test_collision();
    test_drop();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hv_pwm_chn_sched.md
HV_PWM_CHN_SCHED -- requirements
Module: hv_pwm_chn_sched

Interface
REQ-001 The block SHALL use a single clock, i_clk; reset i_rst_n SHALL be synchronous and active-low.
REQ-002 The block SHALL have these parameters:
- REQ_NUM, default 3, number of requesters.
- CODE_W, default 2, message code width.
- GAP_CYC, default 8, idle guard cycles between bursts.
- TO_CYC, default 64, encoder timeout in cycles.
REQ-003 The block SHALL have these ports:
- i_clk  in  1  clock
- i_rst_n  in  1  synchronous active-low reset
- i_req  in  REQ_NUM  per-source request level
- i_req_code  in  REQ_NUM*CODE_W  per-source code; source k occupies bits [k*CODE_W +: CODE_W]
- o_ack  out  REQ_NUM  one-cycle pulse, burst of source k completed
- o_enc_start  out  1  one-cycle start strobe to the PWM burst encoder
- o_enc_code  out  CODE_W  code for the current burst
- i_enc_done  in  1  one-cycle encoder completion pulse
- o_busy  out  1  high in every state except IDLE
- o_to_err  out  1  sticky encoder-timeout flag
- i_err_clr  in  1  clears o_to_err

Function
REQ-004 The FSM SHALL have four states, IDLE, START, WAIT, GAP, held in a registered state variable.
REQ-005 IDLE SHALL stay in IDLE while no i_req bit is high.
- Otherwise, at the next edge, it SHALL record the winner in grant_idx, latch that source's code into o_enc_code, and move to START.
REQ-006 Arbitration SHALL be round-robin.
- The search starts at pointer rr_ptr and runs upward, wrapping from REQ_NUM-1 to 0.
- The first set i_req bit wins.
- rr_ptr resets to 0.
REQ-007 o_enc_start SHALL be high only while in START; START SHALL last exactly one cycle and then go to WAIT.
- A request seen in IDLE at cycle N SHALL give o_enc_start high in cycle N+1.
REQ-008 WAIT SHALL sample i_enc_done every cycle.
- On i_enc_done: pulse o_ack[grant_idx] in the next cycle, set rr_ptr to (grant_idx+1) mod REQ_NUM, and go to GAP.
REQ-009 A timeout counter SHALL clear on entry to WAIT and increment each WAIT cycle.
- When it reaches TO_CYC-1 with no i_enc_done: set o_to_err, emit no o_ack, advance rr_ptr as in REQ-008, and go to GAP.
REQ-010 If i_enc_done and the timeout condition occur in the same cycle, i_enc_done SHALL win: o_ack pulses and o_to_err is unchanged.
REQ-011 i_enc_done SHALL be ignored in IDLE, START and GAP.
REQ-012 GAP SHALL count GAP_CYC cycles and then return to IDLE.
- If GAP_CYC=0, WAIT SHALL go directly to IDLE.
- Requests SHALL NOT be granted during GAP.
REQ-013 Deassertion of i_req[grant_idx] after the grant SHALL NOT abort the burst; the ack still pulses on done.
REQ-014 Changes to i_req_code after the grant SHALL NOT affect o_enc_code until the next grant.
REQ-015 o_to_err SHALL clear on i_err_clr.
- If a timeout set and i_err_clr occur in the same cycle, set SHALL win.
REQ-016 At most one o_ack bit SHALL be high in any cycle, and o_ack and o_enc_start SHALL never be high together.
REQ-017 Counters SHALL be sized $clog2 of their terminal value plus 1 and SHALL NOT wrap; an unreachable FSM state SHALL recover to IDLE.

Reset
REQ-018 While i_rst_n=0 at a clock edge, the block SHALL load these values:
- state=IDLE, rr_ptr=0, grant_idx=0
- o_ack=0, o_enc_start=0, o_enc_code=0, o_busy=0, o_to_err=0
- all counters 0
REQ-019 Reset asserted mid-burst SHALL abort the burst with no o_ack pulse.
- After release, the block SHALL need at least one IDLE cycle before START.

Verification
REQ-020 Single request, reset defaults:
- i_req=3'b010, code 2'b11, i_enc_done 5 cycles after start.
- Required: o_enc_start one cycle later, o_enc_code=2'b11, o_ack=3'b010 pulse, then o_busy high for 8 GAP cycles, then IDLE.
REQ-021 Fairness:
- i_req=3'b111 held high, done returned promptly.
- Required: grants in order 0,1,2,0, with exactly one start per burst and no start during GAP.
REQ-022 Timeout:
- i_req=3'b001, i_enc_done never asserted.
- Required: o_to_err=1 after 64 WAIT cycles, no o_ack, next grant to source 1 if requested.
- i_err_clr then clears o_to_err.
REQ-023 Collision:
- i_enc_done in the last timeout cycle.
- Required: o_ack pulses and o_to_err stays 0.
- Also: i_err_clr coincident with a timeout leaves o_to_err=1.
REQ-024 Request drop and code change:
- Requester drops i_req and changes its code during WAIT.
- Required: o_enc_code unchanged and o_ack still pulses.
- Reset in WAIT: all outputs return to defaults and no o_ack is seen.
